// File: rtl/rv_pkg.sv
// Shared definitions for the valid/ready packing family: default sizes,
// the counter-width helper and the lane-mask generator.
package rv_pkg;

  localparam int WD_DEF = 4;
  localparam int N_DEF  = 4;

  // Bits needed to index v lanes (v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Keep-mask bit for one lane: lanes 0..cnt hold real data.
  function automatic logic lane_mask(input int cnt, input int lane);
    return (lane <= cnt);
  endfunction

endpackage

// File: rtl/rv_pack_if.sv
// Narrow-beat input stream plus wide-word output stream of the packer.
// master = the side that feeds beats and drains words, slave = the packer.
interface rv_pack_if #(
  parameter int WD = rv_pkg::WD_DEF,
  parameter int N  = rv_pkg::N_DEF
);
  logic [WD-1:0]   datain;
  logic            datain_val;
  logic            datain_last;
  logic            datain_rdy;
  logic [WD*N-1:0] dataout;
  logic [N-1:0]    dataout_keep;
  logic            dataout_val;
  logic            dataout_rdy;

  modport master (
    output datain, datain_val, datain_last, dataout_rdy,
    input  datain_rdy, dataout, dataout_keep, dataout_val
  );

  modport slave (
    input  datain, datain_val, datain_last, dataout_rdy,
    output datain_rdy, dataout, dataout_keep, dataout_val
  );
endinterface

// File: rtl/rv_pack_acc.sv
// Beat counter, lane accumulator and merge/keep generation for rv_pack.
// The merged word is combinational: stored lanes below cnt, the live beat
// in lane cnt, zeros above.
module rv_pack_acc
  import rv_pkg::*;
#(
  parameter int WD = WD_DEF,
  parameter int N  = N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            beat_en_i,
  input  logic [WD-1:0]   beat_i,
  input  logic            last_i,
  output logic [WD*N-1:0] word_o,
  output logic [N-1:0]    keep_o,
  output logic            complete_o
);
  localparam int CW = clog2(N);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N-2:0][WD-1:0]   acc_q, acc_d;

  assign complete_o = last_i || (cnt_q == CW'(N - 1));

  // Next counter/accumulator: store a non-completing beat, clear on completion.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (beat_en_i) begin
      if (complete_o) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        for (int i = 0; i < N - 1; i++) begin
          if (32'(cnt_q) == i) acc_d[i] = beat_i;
        end
      end
    end
  end

  // Counter and accumulator state; reset discards any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      if (gi < N - 1) begin : g_stored
        assign word_o[gi*WD +: WD] = (32'(cnt_q) == gi) ? beat_i :
                                     (lane_mask(32'(cnt_q), gi) ? acc_q[gi] : '0);
      end else begin : g_top
        // The top lane is never stored: it only ever carries the live beat.
        assign word_o[gi*WD +: WD] = (32'(cnt_q) == gi) ? beat_i : '0;
      end
      assign keep_o[gi] = lane_mask(32'(cnt_q), gi);
    end
  endgenerate

endmodule

// File: rtl/rv_pack.sv
// Packs n consecutive wd-bit beats into one registered wd*n-bit word with a
// lane keep mask; datain_last closes a word early.
module rv_pack
  import rv_pkg::*;
#(
  parameter int WD = WD_DEF,
  parameter int N  = N_DEF
) (
  input  logic     clk,
  input  logic     rst,
  rv_pack_if.slave bus
);
  logic            rdy;
  logic            accept;
  logic            take;
  logic            complete;
  logic [WD*N-1:0] merged;
  logic [N-1:0]    merged_keep;

  logic [WD*N-1:0] data_q, data_d;
  logic [N-1:0]    keep_q, keep_d;
  logic            val_q, val_d;

  // The slot is free when empty or being drained this cycle.
  assign rdy    = !val_q || bus.dataout_rdy;
  assign accept = bus.datain_val && rdy;
  assign take   = val_q && bus.dataout_rdy;

  rv_pack_acc #(.WD(WD), .N(N)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .beat_en_i  (accept),
    .beat_i     (bus.datain),
    .last_i     (bus.datain_last),
    .word_o     (merged),
    .keep_o     (merged_keep),
    .complete_o (complete)
  );

  // Output slot: a completing beat wins over a take so the new word replaces the old.
  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    val_d  = val_q;
    if (accept && complete) begin
      data_d = merged;
      keep_d = merged_keep;
      val_d  = 1'b1;
    end else if (take) begin
      val_d  = 1'b0;
    end
  end

  // Output register; reset drops any pending word immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      keep_q <= '0;
      val_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      keep_q <= keep_d;
      val_q  <= val_d;
    end
  end

  assign bus.datain_rdy   = rdy;
  assign bus.dataout      = data_q;
  assign bus.dataout_keep = keep_q;
  assign bus.dataout_val  = val_q;

endmodule

// File: tb/tb_rv_pack.sv
// Self-checking bench for rv_pack (wd=4, n=4): directed scenarios plus a
// scoreboard fed by a reference packing model on every accepted beat.
module tb_rv_pack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv_pack_if #(.WD(4), .N(4)) bus ();

  rv_pack #(.WD(4), .N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  k;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;
  int n_take = 0;
  int cyc = 0;

  logic [15:0] m_acc = '0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: values at the falling edge are those the next rising edge samples.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      m_acc = '0;
      m_cnt = 0;
    end else begin
      if (bus.dataout_val && bus.dataout_rdy) begin
        exp_t e;
        n_take++;
        $display("take word=%h keep=%b", bus.dataout, bus.dataout_keep);
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("sb_data", 32'(bus.dataout), 32'(e.d));
          chk("sb_keep", 32'(bus.dataout_keep), 32'(e.k));
        end
      end
      if (bus.datain_val && bus.datain_rdy) begin
        logic [15:0] w;
        n_acc++;
        w = m_acc | (16'(bus.datain) << (4 * m_cnt));
        if (bus.datain_last || m_cnt == 3) begin
          sb.push_back('{d: w, k: 4'((1 << (m_cnt + 1)) - 1)});
          m_acc = '0;
          m_cnt = 0;
        end else begin
          m_acc = w;
          m_cnt++;
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns at rising edge + 1.
  task automatic send(input logic [3:0] d, input logic last);
    int t;
    t = 0;
    bus.datain      = d;
    bus.datain_last = last;
    bus.datain_val  = 1'b1;
    @(negedge clk);
    while (!bus.datain_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.datain_val  = 1'b0;
    bus.datain_last = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    int c0;
    bus.datain      = '0;
    bus.datain_val  = 1'b0;
    bus.datain_last = 1'b0;
    bus.dataout_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", 32'(bus.dataout_val), 32'd0);
    chk("rst_data", 32'(bus.dataout), 32'h0000);
    chk("rst_keep", 32'(bus.dataout_keep), 32'h0);
    chk("rst_rdy", 32'(bus.datain_rdy), 32'd1);
    rst = 1'b1;
    tick();

    // Full word, output valid for exactly one cycle.
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
    chk("full_data", 32'(bus.dataout), 32'h4321);
    chk("full_keep", 32'(bus.dataout_keep), 32'hf);
    chk("full_val", 32'(bus.dataout_val), 32'd1);
    tick();
    chk("full_val_drop", 32'(bus.dataout_val), 32'd0);

    // Early close, then a single-lane word.
    send(4'h5, 1'b0); send(4'hA, 1'b1);
    chk("early_data", 32'(bus.dataout), 32'h00A5);
    chk("early_keep", 32'(bus.dataout_keep), 32'h3);
    send(4'hF, 1'b1);
    chk("one_data", 32'(bus.dataout), 32'h000F);
    chk("one_keep", 32'(bus.dataout_keep), 32'h1);
    tick();

    // Backpressure: word held and input stalled while not taken.
    bus.dataout_rdy = 1'b0;
    send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", 32'(bus.datain_rdy), 32'd0);
      chk("bp_data", 32'(bus.dataout), 32'h8765);
      chk("bp_val", 32'(bus.dataout_val), 32'd1);
      tick();
    end
    bus.dataout_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(bus.datain_rdy), 32'd1);
    tick();
    chk("bp_taken", 32'(bus.dataout_val), 32'd0);

    // Streaming: 8 beats in 8 consecutive cycles.
    a0 = n_acc;
    c0 = cyc;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    chk("stream_beats", 32'(n_acc - a0), 32'd8);
    chk("stream_cycles", 32'(cyc - c0), 32'd8);
    chk("stream_data", 32'(bus.dataout), 32'h8765);
    tick();

    // Reset mid-word discards the partial accumulator.
    send(4'h3, 1'b0); send(4'h3, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_val", 32'(bus.dataout_val), 32'd0);
    tick();
    rst = 1'b1;
    send(4'h9, 1'b0); send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0);
    chk("midrst_data", 32'(bus.dataout), 32'hCBA9);
    chk("midrst_keep", 32'(bus.dataout_keep), 32'hf);
    tick();

    // Asynchronous reset while a word is pending, checked without a clock edge.
    bus.dataout_rdy = 1'b0;
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b1);
    chk("pend_val", 32'(bus.dataout_val), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_val", 32'(bus.dataout_val), 32'd0);
    chk("arst_data", 32'(bus.dataout), 32'h0000);
    chk("arst_keep", 32'(bus.dataout_keep), 32'h0);
    chk("arst_rdy", 32'(bus.datain_rdy), 32'd1);
    tick();
    rst = 1'b1;
    bus.dataout_rdy = 1'b1;
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("take_count", 32'(n_take), 32'd7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rv_pack.md
# rv_pack

Downstream consumer of the `wd`-bit valid/ready pipe-register stage. It accepts a stream of `wd`-bit beats and packs `n` consecutive beats into one `wd*n`-bit word, and it emits that word on a registered valid/ready output. A `datain_last` flag closes a word early; the partial word is marked with a per-lane keep mask. The block sits directly after the single-entry pipe register and feeds wide-word consumers.

## Interface
- `wd`, 4: beat width in bits.
- `n`, 4: beats per packed word; must be at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `datain`  in  `wd`  input beat.
- `datain_val`  in  1  input beat valid.
- `datain_last`  in  1  marks the final beat of a word; qualified by `datain_val`.
- `datain_rdy`  out  1  block can accept a beat this cycle.
- `dataout`  out  `wd*n`  packed word; lane 0 (the first beat) is in the LSBs.
- `dataout_keep`  out  `n`  lane-valid mask; bit i = lane i holds real data.
- `dataout_val`  out  1  packed word valid.
- `dataout_rdy`  in  1  downstream accepts the word.

## Operation
- Handshakes:
  - Input beat accepted on an edge where `datain_val && datain_rdy`.
  - Output word taken on an edge where `dataout_val && dataout_rdy`.
- `datain_rdy = !dataout_val || dataout_rdy`.
  - Combinational from `dataout_rdy` and the output-valid register.
  - Independent of `datain_val` and `datain_last`.
- Beat counter `cnt`, range 0..n-1, is the lane index of the next beat.
- Accumulator holds lanes 0..n-2.
- Non-completing beat (`cnt != n-1` and `!datain_last`):
  - Write `datain` into accumulator lane `cnt`.
  - `cnt` increments.
- Completing beat (`cnt == n-1`, or `datain_last` asserted):
  - Output register is loaded with the accumulator lanes below `cnt`, `datain` in lane `cnt`, and zeros in lanes above `cnt`.
  - `dataout_keep` is loaded with bits 0..cnt set.
  - `dataout_val` is set to 1.
  - `cnt` returns to 0 and the accumulator is cleared.
- Output register, with no completing beat this edge:
  - Word taken: `dataout_val` clears.
  - Otherwise: `dataout`, `dataout_keep` and `dataout_val` hold unchanged.
- Simultaneous take and completing beat on the same edge: the new word replaces the old one and `dataout_val` stays 1.
- `datain_last` on lane 0: a one-lane word with keep = 1.
- `cnt` never exceeds n-1. A completing beat always wraps `cnt` to 0.

## Timing
- Reset values:
  - `dataout`, `dataout_keep`, `dataout_val`: 0.
  - `cnt` and accumulator: 0.
  - `datain_rdy` reads 1 once reset is applied.
- Reset takes effect immediately, without waiting for a clock edge.
  - Mid-word reset discards any partial accumulator.
  - Mid-word reset drops a pending output word; `dataout_val` falls asynchronously.
- Latency: `dataout_val` rises on the same edge that accepts the completing beat.
- Throughput:
  - One beat per cycle.
  - With `dataout_rdy` held high, full words appear every n cycles with no input bubbles.
- Backpressure:
  - While `dataout_val && !dataout_rdy`, `datain_rdy` = 0.
  - `dataout` and `dataout_keep` are stable until taken.
- `datain`, `datain_last` and `datain_val` are sampled only on an accepting edge.

## Structure
- Shared package `rv_pkg` holds:
  - Default `wd` and `n`.
  - A clog2 constant function for the `cnt` width.
  - The lane-mask generator (`cnt` -> keep), shared with a future unpacker.
- One sub-module is natural: `rv_pack_acc`, containing the counter, the accumulator, and merge/keep generation.
  - Its outputs are the merged word, the keep mask and the completion flag.
  - The top level owns the output register and the handshake.

## Test plan
All scenarios use `wd=4`, `n=4`.
- Reset check: assert `rst`=0 mid-run -> `dataout_val`=0, `dataout`=16'h0000, `dataout_keep`=4'b0000, `datain_rdy`=1 with no clock edge needed.
- Full word: beats 1,2,3,4 back-to-back, `dataout_rdy`=1 -> `dataout`=16'h4321, keep=4'b1111, `dataout_val` high for exactly one cycle.
- Early close: beat 5, then beat A with last -> `dataout`=16'h00A5, keep=4'b0011. Then beat F with last -> 16'h000F, keep=4'b0001.
- Backpressure:
  - Complete word 16'h8765 with `dataout_rdy`=0 for 3 cycles -> `datain_rdy`=0 and `dataout` held at 8765.
  - Release `dataout_rdy` -> taken once, and `datain_rdy` returns to 1 the same cycle.
- Streaming: beats 1..8 continuous, `dataout_rdy`=1 -> words 16'h4321 then 16'h8765, with 8 beats accepted in 8 consecutive cycles.
- Reset mid-word: accept beats 3,3, pulse `rst`, then send beats 9,A,B,C -> `dataout`=16'hCBA9, keep=4'b1111, with no residue from the 3s.
